pipe_stat_counter: RTL and testbench
====================================

PIPE_STAT_COUNTER -- requirements
Module: pipe_stat_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of every event counter (legal range 8..32).
REQ-002 SHALL have parameter SAT, default 1, where 1 makes counters saturate at all-ones and 0 makes them wrap to zero.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  CPU step enable; the same signal that gates the CPU core.
REQ-006 SHALL have port clr  input  1  synchronous clear of counters and halt state.
REQ-007 SHALL have port halted  input  1  CPU halt flag from the write-back stage.
REQ-008 SHALL have port jumped  input  1  unconditional jump resolved in EX this cycle.
REQ-009 SHALL have port is_branch  input  1  conditional branch resolved in EX this cycle.
REQ-010 SHALL have port branched  input  1  conditional branch taken in EX this cycle.
REQ-011 SHALL have port load_use  input  1  load-use stall asserted in ID this cycle.
REQ-012 SHALL have port display  input  32  CPU syscall display value.
REQ-013 SHALL have port sel  input  3  readout select.
REQ-014 SHALL have port stat_data  output  32  registered readout, zero-extended from CNT_W.
REQ-015 SHALL have port running  output  1  1 in state RUN, 0 in state HALT.

Function
REQ-016 SHALL hold five counters: CYC (counting cycles), JMP (jumped), BR (is_branch), TK (branched), LU (load_use).
REQ-017 SHALL implement a two-state FSM: RUN and HALT.
REQ-018 SHALL define a qualifying cycle as en=1 and state RUN and halted=0.
REQ-019 SHALL, on a qualifying cycle, increment CYC by 1, and increment each other counter by 1 when its input is 1.
REQ-020 SHALL, when en=1 and state RUN and halted=1, go to HALT and update no counter on that edge.
REQ-021 SHALL, in HALT, freeze all counters and ignore every event input and halted, until rst or clr.
REQ-022 SHALL, when en=0, hold all counters and the FSM state regardless of event inputs or halted.
REQ-023 SHALL, with SAT=1, keep a counter at 2^CNT_W-1 when it is at all-ones and its increment condition occurs.
REQ-024 SHALL, with SAT=0, wrap a counter at 2^CNT_W-1 to 0 when its increment condition occurs.
REQ-025 SHALL, when clr=1 and rst=0, set all counters to 0 and the state to RUN, independent of en.
REQ-026 SHALL give clr priority over counting in the same cycle, so counters become 0, not 1.
REQ-027 SHALL give rst priority over clr.
REQ-028 SHALL register stat_data every clock edge, independent of en and state, from the pre-edge counter values.
REQ-029 SHALL select stat_data as sel=0 display, 1 CYC, 2 JMP, 3 BR, 4 TK, 5 LU, 6 and 7 zero.
REQ-030 SHALL have a readout latency of exactly one cycle from a change of sel or display to stat_data.
REQ-031 SHALL not check consistency between its inputs (for example branched=1 with is_branch=0); each counter counts its own input.
REQ-032 SHALL drive running combinationally from the state register.

Reset
REQ-033 SHALL, at a rising edge with rst=1, set all counters to 0, the state to RUN and stat_data to 0.
REQ-034 SHALL, when rst is asserted mid-run or in HALT, discard all counts and resume counting from 0 on the first qualifying cycle after rst drops.

Verification
REQ-035 SHALL pass this scenario: rst, then en=1 for 10 cycles with jumped=1 on cycles 3 and 7 and load_use=1 on cycle 5, then sel=1/2/5 -> stat_data reads 10, 2 and 1.
REQ-036 SHALL pass this scenario: 4 qualifying cycles, then halted=1 for one cycle, then 5 more cycles with events -> CYC=4, running=0, other counters unchanged.
REQ-037 SHALL pass this scenario: en toggled 1,0,1,0,1 with is_branch=1 and branched=1 throughout -> CYC=3, BR=3, TK=3.
REQ-038 SHALL pass this scenario: CNT_W=8, 300 qualifying cycles -> SAT=1 gives CYC=255; SAT=0 gives CYC=44.
REQ-039 SHALL pass this scenario: in HALT with CYC=20, clr=1 and jumped=1 in the same cycle -> CYC=0, JMP=0, running=1; with rst=1 also asserted, rst result (stat_data=0).
REQ-040 SHALL pass this scenario: display=0x12345678 with sel=0 -> stat_data=0x12345678 exactly one edge later; sel=6 -> 0.

Source files
------------

// File: rtl/pipe_stat_counter.sv
// pipe_stat_counter: pipeline event statistics for a stepped CPU core.
// Five event counters (cycles, jumps, branches, taken branches, load-use
// stalls) advance only on cycles where the core steps and has not halted.
// A two-state RUN/HALT machine freezes the counters once the core halts.
// stat_data is a registered readout mux over the counters and the display value.
module pipe_stat_counter #(
  parameter int CNT_W = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        halted,
  input  logic        jumped,
  input  logic        is_branch,
  input  logic        branched,
  input  logic        load_use,
  input  logic [31:0] display,
  input  logic [2:0]  sel,
  output logic [31:0] stat_data,
  output logic        running
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               qualify_s;
  logic [CNT_W-1:0]   cyc_r;
  logic [CNT_W-1:0]   jmp_r;
  logic [CNT_W-1:0]   br_r;
  logic [CNT_W-1:0]   tk_r;
  logic [CNT_W-1:0]   lu_r;
  logic [31:0]        readout_s;

  // Advance a counter by one when its event fires; at all-ones either hold
  // (saturating build) or roll over to zero (wrapping build).
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                            input logic             ev);
    logic [CNT_W-1:0] r;
    if (!ev) begin
      r = v;
    end else if (v == {CNT_W{1'b1}}) begin
      r = SAT ? v : {CNT_W{1'b0}};
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Zero-extend a counter value onto the 32-bit readout bus.
  function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  // A counting cycle: the core steps, we are still in RUN, and it is not halting.
  assign qualify_s = en && (state_r == RUN) && !halted;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: clr always returns to RUN; a stepped halt enters HALT,
  // which is sticky until rst or clr.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = RUN;
    end else if (en && (state_r == RUN) && halted) begin
      state_nxt_s = HALT;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output logic: running reflects the state register directly.
  always_comb begin
    running = 1'b0;
    case (state_r)
      RUN:     running = 1'b1;
      HALT:    running = 1'b0;
      default: running = 1'b0;
    endcase
  end

  // Event counters: rst and clr both zero them (clr wins over counting),
  // otherwise they advance only on qualifying cycles.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cyc_r <= {CNT_W{1'b0}};
      jmp_r <= {CNT_W{1'b0}};
      br_r  <= {CNT_W{1'b0}};
      tk_r  <= {CNT_W{1'b0}};
      lu_r  <= {CNT_W{1'b0}};
    end else if (qualify_s) begin
      cyc_r <= bump(cyc_r, 1'b1);
      jmp_r <= bump(jmp_r, jumped);
      br_r  <= bump(br_r,  is_branch);
      tk_r  <= bump(tk_r,  branched);
      lu_r  <= bump(lu_r,  load_use);
    end else begin
      cyc_r <= cyc_r;
      jmp_r <= jmp_r;
      br_r  <= br_r;
      tk_r  <= tk_r;
      lu_r  <= lu_r;
    end
  end

  // Readout select over the pre-edge counter values.
  always_comb begin
    readout_s = 32'd0;
    case (sel)
      3'd0:    readout_s = display;
      3'd1:    readout_s = zext(cyc_r);
      3'd2:    readout_s = zext(jmp_r);
      3'd3:    readout_s = zext(br_r);
      3'd4:    readout_s = zext(tk_r);
      3'd5:    readout_s = zext(lu_r);
      default: readout_s = 32'd0;
    endcase
  end

  // Readout register: updated every edge regardless of en or state.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_data <= 32'd0;
    end else begin
      stat_data <= readout_s;
    end
  end

endmodule

// File: tb/tb_pipe_stat_counter.sv
// Directed testbench for pipe_stat_counter: a default 32-bit saturating
// instance plus two 8-bit instances (saturating and wrapping) sharing stimulus.
module tb_pipe_stat_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic        halted;
  logic        jumped;
  logic        is_branch;
  logic        branched;
  logic        load_use;
  logic [31:0] display;
  logic [2:0]  sel;
  logic [31:0] stat_data;
  logic        running;
  logic [31:0] stat_data_s8;
  logic        running_s8;
  logic [31:0] stat_data_w8;
  logic        running_w8;

  int n_vec;
  int n_err;

  pipe_stat_counter dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .halted(halted),
    .jumped(jumped), .is_branch(is_branch), .branched(branched),
    .load_use(load_use), .display(display), .sel(sel),
    .stat_data(stat_data), .running(running)
  );

  pipe_stat_counter #(.CNT_W(8), .SAT(1'b1)) dut_s8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .halted(halted),
    .jumped(jumped), .is_branch(is_branch), .branched(branched),
    .load_use(load_use), .display(display), .sel(sel),
    .stat_data(stat_data_s8), .running(running_s8)
  );

  pipe_stat_counter #(.CNT_W(8), .SAT(1'b0)) dut_w8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .halted(halted),
    .jumped(jumped), .is_branch(is_branch), .branched(branched),
    .load_use(load_use), .display(display), .sel(sel),
    .stat_data(stat_data_w8), .running(running_w8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_events();
    jumped = 1'b0; is_branch = 1'b0; branched = 1'b0; load_use = 1'b0; halted = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; idle_events();
    step();
    rst = 1'b0;
  endtask

  // Read a counter through the mux with en low so no state changes.
  task automatic read_sel(input logic [2:0] s);
    en = 1'b0; clr = 1'b0; idle_events();
    sel = s;
    step();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b0; en = 1'b0; clr = 1'b0; idle_events();
    display = 32'd0; sel = 3'd1;

    // Reset state
    do_reset();
    check("rst_stat", stat_data, 32'd0);
    check("rst_run", {31'd0, running}, 32'd1);

    // Scenario: 10 cycles, jumps on 3 and 7, load-use on 5
    for (int i = 1; i <= 10; i++) begin
      en = 1'b1;
      jumped = (i == 3 || i == 7) ? 1'b1 : 1'b0;
      load_use = (i == 5) ? 1'b1 : 1'b0;
      step();
    end
    read_sel(3'd1); check("s1_cyc", stat_data, 32'd10);
    read_sel(3'd2); check("s1_jmp", stat_data, 32'd2);
    read_sel(3'd5); check("s1_lu",  stat_data, 32'd1);
    read_sel(3'd3); check("s1_br",  stat_data, 32'd0);

    // Scenario: 4 qualifying cycles, halt, then 5 ignored cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; is_branch = 1'b1;
      step();
    end
    en = 1'b1; halted = 1'b1; jumped = 1'b1; is_branch = 1'b1;
    step();
    check("s2_halt_run", {31'd0, running}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; halted = i[0]; jumped = 1'b1; is_branch = 1'b1;
      branched = 1'b1; load_use = 1'b1;
      step();
    end
    read_sel(3'd1); check("s2_cyc", stat_data, 32'd4);
    read_sel(3'd3); check("s2_br",  stat_data, 32'd4);
    read_sel(3'd2); check("s2_jmp", stat_data, 32'd0);
    read_sel(3'd5); check("s2_lu",  stat_data, 32'd0);
    check("s2_run", {31'd0, running}, 32'd0);

    // Scenario: en toggled 1,0,1,0,1; halted high while en low must not halt
    do_reset();
    for (int i = 0; i < 5; i++) begin
      en = (i % 2 == 0) ? 1'b1 : 1'b0;
      halted = (i % 2 == 0) ? 1'b0 : 1'b1;
      is_branch = 1'b1; branched = 1'b1;
      step();
    end
    read_sel(3'd1); check("s3_cyc", stat_data, 32'd3);
    read_sel(3'd3); check("s3_br",  stat_data, 32'd3);
    read_sel(3'd4); check("s3_tk",  stat_data, 32'd3);
    check("s3_run", {31'd0, running}, 32'd1);

    // Scenario: 300 qualifying cycles, saturating vs wrapping 8-bit counters
    do_reset();
    for (int i = 0; i < 300; i++) begin
      en = 1'b1; jumped = 1'b1;
      step();
    end
    read_sel(3'd1);
    check("s4_cyc32",  stat_data,    32'd300);
    check("s4_cyc_s8", stat_data_s8, 32'd255);
    check("s4_cyc_w8", stat_data_w8, 32'd44);
    read_sel(3'd2);
    check("s4_jmp_s8", stat_data_s8, 32'd255);
    check("s4_jmp_w8", stat_data_w8, 32'd44);

    // Scenario: clr in HALT with a jump in the same cycle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      en = 1'b1;
      step();
    end
    en = 1'b1; halted = 1'b1;
    step();
    read_sel(3'd1); check("s5_cyc20", stat_data, 32'd20);
    check("s5_halted", {31'd0, running}, 32'd0);
    en = 1'b1; clr = 1'b1; jumped = 1'b1; halted = 1'b0;
    step();
    clr = 1'b0;
    check("s5_clr_run", {31'd0, running}, 32'd1);
    read_sel(3'd1); check("s5_clr_cyc", stat_data, 32'd0);
    read_sel(3'd2); check("s5_clr_jmp", stat_data, 32'd0);

    // clr beats counting while in RUN
    en = 1'b1; clr = 1'b1; jumped = 1'b1;
    step();
    read_sel(3'd1); check("s5_clrprio_cyc", stat_data, 32'd0);
    read_sel(3'd2); check("s5_clrprio_jmp", stat_data, 32'd0);

    // rst beats clr: readout is zero rather than the pre-edge count
    for (int i = 0; i < 3; i++) begin
      en = 1'b1;
      step();
    end
    sel = 3'd1; rst = 1'b1; clr = 1'b1; en = 1'b1;
    step();
    check("s5_rstclr_stat", stat_data, 32'd0);
    rst = 1'b0; clr = 1'b0;
    read_sel(3'd1); check("s5_rst_cyc", stat_data, 32'd0);
    en = 1'b1;
    step(); step();
    read_sel(3'd1); check("s5_resume_cyc", stat_data, 32'd2);

    // Scenario: display readout latency and unused selects
    en = 1'b0; sel = 3'd0; display = 32'h1234_5678;
    #1;
    check("s6_pre_edge", stat_data, 32'd2);
    step();
    check("s6_disp", stat_data, 32'h1234_5678);
    sel = 3'd6;
    step();
    check("s6_sel6", stat_data, 32'd0);
    sel = 3'd0; display = 32'hA5A5_0F0F;
    step();
    check("s6_disp2", stat_data, 32'hA5A5_0F0F);
    sel = 3'd7;
    step();
    check("s6_sel7", stat_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
